// File: rtl/conv_ctrl_pkg.sv
// Shared control definitions for the conv_pixels tiling sequencers.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package conv_ctrl_pkg;

  localparam int CTRL_DW   = 16;
  localparam int CTRL_OY_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } ctrl_state_t;

  localparam logic [3:0] STRIDE_1 = 4'd1;
  localparam logic [3:0] STRIDE_2 = 4'd2;

  // conv_pixels only implements unit and double stride
  function automatic logic stride_legal(input logic [3:0] s);
    return (s == STRIDE_1) || (s == STRIDE_2);
  endfunction

endpackage

// File: rtl/conv_row_tiler_tile_step.sv
// One horizontal tile step: next 1-based tile start and whether cur_start is the row's last tile.
// Latency: combinational.
// Backpressure: none.
module tile_step #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] cur_start,
  input  logic [DW-1:0] pox,
  input  logic [DW-1:0] ox,
  output logic [DW-1:0] nxt_start,
  output logic          last_tile
);

  logic [DW:0] sum;

  // one extra bit so a start near the top of the range cannot wrap into a false "more tiles"
  always_comb begin
    sum       = {1'b0, cur_start} + {1'b0, pox};
    last_tile = (sum > {1'b0, ox});
    nxt_start = last_tile ? DW'(1) : sum[DW-1:0];
  end

endmodule

// File: rtl/conv_row_tiler.sv
// Walks ox_start/next_ox_start over every Pox-wide tile of every output row for conv_pixels.
// Latency: start -> pix_en 1 cycle; pix_end -> new ox_start on the same edge; last pix_end -> done 1 cycle later.
// Backpressure: none; the sweep advances only on pix_end and waits indefinitely for it.
module conv_row_tiler
  import conv_ctrl_pkg::*;
#(
  parameter int DW   = CTRL_DW,
  parameter int OY_W = CTRL_OY_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [DW-1:0]   ox,
  input  logic [OY_W-1:0] oy,
  input  logic [DW-1:0]   pox_in,
  input  logic [3:0]      s_in,
  input  logic            abort,
  input  logic            pix_end,
  output logic [DW-1:0]   ox_start,
  output logic [DW-1:0]   next_ox_start,
  output logic [DW-1:0]   pox,
  output logic            pix_en,
  output logic            tiling_end,
  output logic [OY_W-1:0] oy_idx,
  output logic            busy,
  output logic            done,
  output logic            cfg_err
);

  ctrl_state_t     state, state_nxt;
  logic [DW-1:0]   ox_q;
  logic [OY_W-1:0] oy_q;
  logic            cfg_legal;
  logic            last_tile;
  logic            last_row;
  logic [DW-1:0]   cur_adv;

  // lookahead step operands: seeded from the raw inputs at start, from latched config afterwards
  logic [DW-1:0]   la_cur;
  logic [DW-1:0]   la_pox;
  logic [DW-1:0]   la_ox;
  logic [DW-1:0]   la_nxt;
  logic            la_last_unused;

  // stride is qualified here only; the stride arithmetic itself lives in conv_pixels
  assign cfg_legal = (ox != '0) && (oy != '0) && (pox_in != '0) && stride_legal(s_in);
  assign last_row  = (oy_idx == (oy_q - OY_W'(1)));

  // lookahead restarts at column 1 on a new sweep or row, otherwise steps from next_ox_start
  always_comb begin
    la_cur = ((state == ST_RUN) && !last_tile) ? next_ox_start : DW'(1);
    la_pox = (state == ST_IDLE) ? pox_in : pox;
    la_ox  = (state == ST_IDLE) ? ox : ox_q;
  end

  tile_step #(.DW(DW)) u_step_cur (
    .cur_start (ox_start),
    .pox       (pox),
    .ox        (ox_q),
    .nxt_start (cur_adv),
    .last_tile (last_tile)
  );

  tile_step #(.DW(DW)) u_step_lookahead (
    .cur_start (la_cur),
    .pox       (la_pox),
    .ox        (la_ox),
    .nxt_start (la_nxt),
    .last_tile (la_last_unused)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // next state and state-decoded strobes
  always_comb begin
    state_nxt  = state;
    pix_en     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    tiling_end = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && cfg_legal) state_nxt = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        // en is pulsed even if abort is already up; the abort then lands in RUN
        pix_en    = 1'b1;
        busy      = 1'b1;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy       = 1'b1;
        tiling_end = abort || (pix_end && last_tile && last_row);
        if (abort)                                  state_nxt = ST_IDLE;
        else if (pix_end && last_tile && last_row)  state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // config latch, tile/row counters and the rejected-start pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      ox_start      <= DW'(1);
      next_ox_start <= DW'(1);
      pox           <= '0;
      oy_idx        <= '0;
      ox_q          <= '0;
      oy_q          <= '0;
      cfg_err       <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (cfg_legal) begin
              ox_q          <= ox;
              oy_q          <= oy;
              pox           <= pox_in;
              ox_start      <= DW'(1);
              oy_idx        <= '0;
              next_ox_start <= la_nxt;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            ox_start      <= DW'(1);
            next_ox_start <= DW'(1);
            oy_idx        <= '0;
          end else if (pix_end) begin
            if (!last_tile) begin
              ox_start      <= cur_adv;
              next_ox_start <= la_nxt;
            end else if (!last_row) begin
              ox_start      <= DW'(1);
              next_ox_start <= la_nxt;
              oy_idx        <= oy_idx + OY_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_row_tiler.sv
// Self-checking bench for conv_row_tiler: config table, directed sweeps, randomized sweeps.
// Latency: n/a.
// Backpressure: n/a.
module tb_conv_row_tiler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] ox;
  logic [15:0] oy;
  logic [15:0] pox_in;
  logic [3:0]  s_in;
  logic        abort;
  logic        pix_end;
  logic [15:0] ox_start;
  logic [15:0] next_ox_start;
  logic [15:0] pox;
  logic        pix_en;
  logic        tiling_end;
  logic [15:0] oy_idx;
  logic        busy;
  logic        done;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_row_tiler dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .ox            (ox),
    .oy            (oy),
    .pox_in        (pox_in),
    .s_in          (s_in),
    .abort         (abort),
    .pix_end       (pix_end),
    .ox_start      (ox_start),
    .next_ox_start (next_ox_start),
    .pox           (pox),
    .pix_en        (pix_en),
    .tiling_end    (tiling_end),
    .oy_idx        (oy_idx),
    .busy          (busy),
    .done          (done),
    .cfg_err       (cfg_err)
  );

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected tile list: for each row, starts 1, 1+pox, 1+2*pox, ... while <= ox.
  // Each tile's successor is the next start in the row, or 1 when the row is exhausted.
  task automatic sweep(input int ox_v, input int oy_v, input int pox_v,
                       input int abort_at, input int gap_max, input bit rnd);
    int es[$];
    int en[$];
    int ey[$];
    int n;
    int ab;
    bit aborting;
    for (int r = 0; r < oy_v; r++)
      for (int s = 1; s <= ox_v; s += pox_v) begin
        es.push_back(s);
        en.push_back((s + pox_v > ox_v) ? 1 : s + pox_v);
        ey.push_back(r);
      end
    n  = es.size();
    ab = abort_at;
    if (rnd && ($urandom_range(0, 3) == 0)) ab = $urandom_range(1, n);

    @(negedge clk);
    start  = 1'b1;
    ox     = 16'(ox_v);
    oy     = 16'(oy_v);
    pox_in = 16'(pox_v);
    s_in   = rnd ? 4'($urandom_range(1, 2)) : 4'd1;
    @(negedge clk);
    start = 1'b0;
    check("launch_pix_en", int'(pix_en), 1);
    check("launch_busy", int'(busy), 1);
    check("launch_pox", int'(pox), pox_v);
    @(negedge clk);
    check("run_pix_en_once", int'(pix_en), 0);

    for (int k = 0; k < n; k++) begin
      int gap;
      gap = rnd ? int'($urandom_range(0, gap_max)) : gap_max;
      for (int g = 0; g < gap; g++) begin
        #1 check("te_idle", int'(tiling_end), 0);
        @(negedge clk);
      end
      check("ox_start", int'(ox_start), es[k]);
      check("next_ox_start", int'(next_ox_start), en[k]);
      check("oy_idx", int'(oy_idx), ey[k]);
      check("busy_run", int'(busy), 1);
      aborting = (k + 1 == ab);
      pix_end  = 1'b1;
      abort    = aborting;
      #1 check("tiling_end", int'(tiling_end), (aborting || k == n - 1) ? 1 : 0);
      @(negedge clk);
      pix_end = 1'b0;
      abort   = 1'b0;
      if (aborting) begin
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_ox_start", int'(ox_start), 1);
        check("abort_next", int'(next_ox_start), 1);
        check("abort_oy_idx", int'(oy_idx), 0);
        return;
      end
    end
    check("done_pulse", int'(done), 1);
    check("done_busy", int'(busy), 0);
    check("done_hold_ox_start", int'(ox_start), es[n-1]);
    check("done_hold_oy_idx", int'(oy_idx), ey[n-1]);
    #1 check("done_te", int'(tiling_end), 0);
    @(negedge clk);
    check("done_once", int'(done), 0);
    check("idle_busy", int'(busy), 0);
  endtask

  typedef struct {
    int ox_v;
    int oy_v;
    int pox_v;
    int s_v;
    bit exp_err;
  } cfg_vec_t;

  cfg_vec_t cfg_tab[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    cfg_tab[0] = '{64, 2, 0, 1, 1'b1};
    cfg_tab[1] = '{64, 2, 32, 3, 1'b1};
    cfg_tab[2] = '{0, 2, 32, 1, 1'b1};
    cfg_tab[3] = '{64, 0, 32, 1, 1'b1};
    cfg_tab[4] = '{64, 2, 32, 0, 1'b1};
    cfg_tab[5] = '{64, 2, 32, 2, 1'b0};
    cfg_tab[6] = '{1, 1, 1, 1, 1'b0};
    cfg_tab[7] = '{65535, 1, 65535, 2, 1'b0};

    reset = 1'b1; start = 1'b0; abort = 1'b0; pix_end = 1'b0;
    ox = 16'd0; oy = 16'd0; pox_in = 16'd0; s_in = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_ox_start", int'(ox_start), 1);
    check("rst_next", int'(next_ox_start), 1);
    check("rst_pox", int'(pox), 0);
    check("rst_oy_idx", int'(oy_idx), 0);
    check("rst_pix_en", int'(pix_en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_cfg_err", int'(cfg_err), 0);
    check("rst_te", int'(tiling_end), 0);
    reset = 1'b0;

    // start legality table
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start  = 1'b1;
      ox     = 16'(cfg_tab[i].ox_v);
      oy     = 16'(cfg_tab[i].oy_v);
      pox_in = 16'(cfg_tab[i].pox_v);
      s_in   = 4'(cfg_tab[i].s_v);
      @(negedge clk);
      start = 1'b0;
      check("cfg_err", int'(cfg_err), int'(cfg_tab[i].exp_err));
      check("cfg_busy", int'(busy), int'(!cfg_tab[i].exp_err));
      check("cfg_pix_en", int'(pix_en), int'(!cfg_tab[i].exp_err));
      if (cfg_tab[i].exp_err) begin
        @(negedge clk);
        check("cfg_err_once", int'(cfg_err), 0);
        check("cfg_err_idle", int'(busy), 0);
      end else begin
        @(negedge clk);
        abort = 1'b1;
        #1 check("cfg_abort_te", int'(tiling_end), 1);
        @(negedge clk);
        abort = 1'b0;
        check("cfg_abort_busy", int'(busy), 0);
        check("cfg_abort_done", int'(done), 0);
      end
    end

    // directed sweeps
    sweep(64, 2, 32, 0, 9, 1'b0);
    sweep(70, 1, 32, 0, 2, 1'b0);
    sweep(20, 1, 32, 0, 1, 1'b0);
    sweep(64, 4, 32, 2, 1, 1'b0);
    sweep(64, 1, 32, 0, 0, 1'b0);
    sweep(65535, 1, 32768, 0, 0, 1'b0);

    // reset in the middle of a sweep, after three tiles
    @(negedge clk);
    start = 1'b1; ox = 16'd64; oy = 16'd4; pox_in = 16'd16; s_in = 4'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      pix_end = 1'b1;
      #1 check("mid_te", int'(tiling_end), 0);
      @(negedge clk);
      pix_end = 1'b0;
    end
    check("mid_ox_start", int'(ox_start), 49);
    reset = 1'b1;
    #1 check("mid_rst_te", int'(tiling_end), 0);
    @(negedge clk);
    check("mid_rst_ox_start", int'(ox_start), 1);
    check("mid_rst_next", int'(next_ox_start), 1);
    check("mid_rst_pox", int'(pox), 0);
    check("mid_rst_oy_idx", int'(oy_idx), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_pix_en", int'(pix_en), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_te2", int'(tiling_end), 0);
    reset = 1'b0;

    // randomized sweeps against the tile-list model
    for (int t = 0; t < 20; t++)
      sweep(int'($urandom_range(1, 80)), int'($urandom_range(1, 3)),
            int'($urandom_range(1, 40)), 0, 3, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
